// File: rtl/ifu_lsu_bus_arbiter_pkg.sv
// Shared types and constants for the fetch/LSU bus arbiter: FSM state
// encodings and the owner codes that tag the in-flight transaction.
package ifu_lsu_bus_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_ADDR = 2'd1,
        ARB_WAIT = 2'd2,
        ARB_DONE = 2'd3
    } arb_state_e;

    localparam logic OWNER_IF  = 1'b0;
    localparam logic OWNER_MEM = 1'b1;

endpackage

// File: rtl/ifu_lsu_bus_arbiter_if.sv
// Request, completion and core-bus signals of the arbiter. The slave modport is
// the arbiter's view; the master modport is the surrounding fetch/LSU/bus side.
interface ifu_lsu_bus_arbiter_if #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
);
    localparam int MASK_W = DATA_W / 8;

    logic              IfReq;
    logic [ADDR_W-1:0] IfAddr;
    logic              IfDone;
    logic [DATA_W-1:0] IfRData;
    logic              IfErr;

    logic              MemReq;
    logic              MemWe;
    logic [ADDR_W-1:0] MemAddr;
    logic [DATA_W-1:0] MemWData;
    logic [MASK_W-1:0] MemWMask;
    logic              MemDone;
    logic [DATA_W-1:0] MemRData;
    logic              MemErr;

    logic              BusValid;
    logic [ADDR_W-1:0] BusAddr;
    logic              BusWe;
    logic [DATA_W-1:0] BusWData;
    logic [MASK_W-1:0] BusWMask;
    logic              BusReady;
    logic              BusRespValid;
    logic [DATA_W-1:0] BusRData;
    logic              BusRespErr;

    modport slave (
        input  IfReq, IfAddr, MemReq, MemWe, MemAddr, MemWData, MemWMask,
               BusReady, BusRespValid, BusRData, BusRespErr,
        output IfDone, IfRData, IfErr, MemDone, MemRData, MemErr,
               BusValid, BusAddr, BusWe, BusWData, BusWMask
    );

    modport master (
        output IfReq, IfAddr, MemReq, MemWe, MemAddr, MemWData, MemWMask,
               BusReady, BusRespValid, BusRData, BusRespErr,
        input  IfDone, IfRData, IfErr, MemDone, MemRData, MemErr,
               BusValid, BusAddr, BusWe, BusWData, BusWMask
    );

endinterface

// File: rtl/ifu_lsu_bus_arbiter_rr_arbiter2.sv
// Two-input round-robin picker: a lone requester wins, a tie goes to the
// requester that did not win last time. Bit 0 is fetch, bit 1 is LSU.
module rr_arbiter2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] grant,
    output logic       any
);

    // NOTE: every output of a combinational block gets a default before the
    // case so that no path leaves it unassigned and infers a latch.
    always_comb begin
        grant = 2'b00;
        case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = last ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end

    assign any = |req;

endmodule

// File: rtl/ifu_lsu_bus_arbiter.sv
// Shares the single core memory bus between instruction fetch and the LSU with
// one outstanding transaction and a watchdog that turns a hung response into an error.
module ifu_lsu_bus_arbiter
    import ifu_lsu_bus_arbiter_pkg::*;
#(
    parameter int ADDR_W  = 64,
    parameter int DATA_W  = 64,
    parameter int TIMEOUT = 255
) (
    input  logic                  Clk,
    input  logic                  Rst,
    ifu_lsu_bus_arbiter_if.slave  bus
);

    localparam int MASK_W = DATA_W / 8;
    localparam int CNT_W  = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

    arb_state_e        state_q, state_d;
    logic              owner_q, owner_d;
    logic              last_grant_q, last_grant_d;
    logic              bus_valid_q, bus_valid_d;
    logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
    logic              bus_we_q, bus_we_d;
    logic [DATA_W-1:0] bus_wdata_q, bus_wdata_d;
    logic [MASK_W-1:0] bus_wmask_q, bus_wmask_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              if_done_q, if_done_d;
    logic              if_err_q, if_err_d;
    logic              mem_done_q, mem_done_d;
    logic              mem_err_q, mem_err_d;

    logic [1:0]        grant;
    logic              any_req;
    logic [CNT_W-1:0]  cnt_inc;
    logic              resp_now;
    logic              resp_err;
    logic [DATA_W-1:0] resp_data;

    rr_arbiter2 u_rr (
        .req   ({bus.MemReq, bus.IfReq}),
        .last  (last_grant_q),
        .grant (grant),
        .any   (any_req)
    );

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        bus_valid_d  = bus_valid_q;
        bus_addr_d   = bus_addr_q;
        bus_we_d     = bus_we_q;
        bus_wdata_d  = bus_wdata_q;
        bus_wmask_d  = bus_wmask_q;
        cnt_d        = cnt_q;
        rdata_d      = rdata_q;
        if_done_d    = 1'b0;
        if_err_d     = 1'b0;
        mem_done_d   = 1'b0;
        mem_err_d    = 1'b0;
        // Saturating so a stuck WAIT can never wrap back below TIMEOUT.
        cnt_inc      = (cnt_q == TIMEOUT_C) ? cnt_q : cnt_q + CNT_W'(1);
        resp_now     = 1'b0;
        resp_err     = 1'b0;
        resp_data    = '0;

        case (state_q)
            ARB_IDLE: begin
                if (any_req) begin
                    if (grant[1]) begin
                        owner_d     = OWNER_MEM;
                        bus_addr_d  = bus.MemAddr;
                        bus_we_d    = bus.MemWe;
                        bus_wdata_d = bus.MemWData;
                        bus_wmask_d = bus.MemWMask;
                    end else if (grant[0]) begin
                        owner_d     = OWNER_IF;
                        bus_addr_d  = bus.IfAddr;
                        bus_we_d    = 1'b0;
                        bus_wdata_d = '0;
                        bus_wmask_d = '0;
                    end
                    bus_valid_d = 1'b1;
                    state_d     = ARB_ADDR;
                end
            end
            ARB_ADDR: begin
                if (bus.BusReady) begin
                    bus_valid_d  = 1'b0;
                    cnt_d        = '0;
                    last_grant_d = owner_q;
                    state_d      = ARB_WAIT;
                end
            end
            ARB_WAIT: begin
                cnt_d = cnt_inc;
                // A response on the timeout edge still wins and keeps its own error flag.
                if (bus.BusRespValid) begin
                    resp_now  = 1'b1;
                    resp_err  = bus.BusRespErr;
                    resp_data = bus.BusRData;
                end else if (cnt_inc == TIMEOUT_C) begin
                    resp_now  = 1'b1;
                    resp_err  = 1'b1;
                end
                if (resp_now) begin
                    rdata_d    = resp_data;
                    if_done_d  = (owner_q == OWNER_IF);
                    if_err_d   = (owner_q == OWNER_IF) && resp_err;
                    mem_done_d = (owner_q == OWNER_MEM);
                    mem_err_d  = (owner_q == OWNER_MEM) && resp_err;
                    state_d    = ARB_DONE;
                end
            end
            ARB_DONE: state_d = ARB_IDLE;
            default:  state_d = ARB_IDLE;
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q      <= ARB_IDLE;
            owner_q      <= OWNER_IF;
            last_grant_q <= OWNER_IF;
            bus_valid_q  <= 1'b0;
            bus_addr_q   <= '0;
            bus_we_q     <= 1'b0;
            bus_wdata_q  <= '0;
            bus_wmask_q  <= '0;
            cnt_q        <= '0;
            rdata_q      <= '0;
            if_done_q    <= 1'b0;
            if_err_q     <= 1'b0;
            mem_done_q   <= 1'b0;
            mem_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            bus_valid_q  <= bus_valid_d;
            bus_addr_q   <= bus_addr_d;
            bus_we_q     <= bus_we_d;
            bus_wdata_q  <= bus_wdata_d;
            bus_wmask_q  <= bus_wmask_d;
            cnt_q        <= cnt_d;
            rdata_q      <= rdata_d;
            if_done_q    <= if_done_d;
            if_err_q     <= if_err_d;
            mem_done_q   <= mem_done_d;
            mem_err_q    <= mem_err_d;
        end
    end

    assign bus.BusValid = bus_valid_q;
    assign bus.BusAddr  = bus_addr_q;
    assign bus.BusWe    = bus_we_q;
    assign bus.BusWData = bus_wdata_q;
    assign bus.BusWMask = bus_wmask_q;
    assign bus.IfDone   = if_done_q;
    assign bus.IfRData  = rdata_q;
    assign bus.IfErr    = if_err_q;
    assign bus.MemDone  = mem_done_q;
    assign bus.MemRData = rdata_q;
    assign bus.MemErr   = mem_err_q;

endmodule

// File: tb/tb_ifu_lsu_bus_arbiter.sv
// Bench for ifu_lsu_bus_arbiter: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against a transaction-level model.
module tb_ifu_lsu_bus_arbiter;
    import ifu_lsu_bus_arbiter_pkg::*;

    localparam int ADDR_W  = 64;
    localparam int DATA_W  = 64;
    localparam int TIMEOUT = 8;

    logic Clk = 1'b0;
    logic Rst = 1'b1;
    always #5 Clk = ~Clk;

    ifu_lsu_bus_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    ifu_lsu_bus_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
        .Clk (Clk),
        .Rst (Rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level model: a busy flag plus the cycle stamps of the address
    // handshake and of the completion decide every expected output.
    bit          m_on = 1'b0, m_busy = 1'b0, m_owner = 1'b0, m_last = 1'b0, m_we = 1'b0;
    int          m_cyc = 0, m_hs = -1, m_done = -1;
    logic [63:0] m_addr = '0, m_wdata = '0, e_rdata = '0;
    logic [7:0]  m_wmask = '0;
    bit          e_valid = 1'b0, e_if_done = 1'b0, e_mem_done = 1'b0, e_err = 1'b0;

    initial forever begin
        @(posedge Clk);
        m_cyc++;
        e_if_done  = 1'b0;
        e_mem_done = 1'b0;
        if (Rst) begin
            m_on = 1'b1; m_busy = 1'b0; m_last = OWNER_IF; e_valid = 1'b0;
            m_addr = '0; m_we = 1'b0; m_wdata = '0; m_wmask = '0; e_rdata = '0; e_err = 1'b0;
        end else if (m_on) begin
            if (!m_busy) begin
                if (bus.IfReq || bus.MemReq) begin
                    if (bus.IfReq && bus.MemReq) m_owner = (m_last == OWNER_IF) ? OWNER_MEM : OWNER_IF;
                    else m_owner = bus.MemReq;
                    if (m_owner == OWNER_MEM) begin
                        m_addr = bus.MemAddr; m_we = bus.MemWe; m_wdata = bus.MemWData; m_wmask = bus.MemWMask;
                    end else begin
                        m_addr = bus.IfAddr; m_we = 1'b0; m_wdata = '0; m_wmask = '0;
                    end
                    m_busy = 1'b1; m_hs = -1; m_done = -1; e_valid = 1'b1;
                end
            end else if (m_hs < 0) begin
                if (bus.BusReady) begin
                    m_hs = m_cyc; m_last = m_owner; e_valid = 1'b0;
                end
            end else if (m_done < 0) begin
                if (bus.BusRespValid) begin
                    m_done = m_cyc; e_rdata = bus.BusRData; e_err = bus.BusRespErr;
                end else if (m_cyc - m_hs == TIMEOUT) begin
                    m_done = m_cyc; e_rdata = '0; e_err = 1'b1;
                end
                if (m_done >= 0) begin
                    e_if_done  = (m_owner == OWNER_IF);
                    e_mem_done = (m_owner == OWNER_MEM);
                end
            end else begin
                m_busy = 1'b0;
            end
        end
    end

    initial forever begin
        @(negedge Clk);
        if (m_on) begin
            check("m_BusValid", 64'(bus.BusValid), 64'(e_valid));
            check("m_IfDone", 64'(bus.IfDone), 64'(e_if_done));
            check("m_MemDone", 64'(bus.MemDone), 64'(e_mem_done));
            if (e_valid) begin
                check("m_BusAddr", bus.BusAddr, m_addr);
                check("m_BusWe", 64'(bus.BusWe), 64'(m_we));
                if (m_we) begin
                    check("m_BusWData", bus.BusWData, m_wdata);
                    check("m_BusWMask", 64'(bus.BusWMask), 64'(m_wmask));
                end
            end
            if (e_if_done) begin
                check("m_IfRData", bus.IfRData, e_rdata);
                check("m_IfErr", 64'(bus.IfErr), 64'(e_err));
            end
            if (e_mem_done) begin
                check("m_MemErr", 64'(bus.MemErr), 64'(e_err));
                if (!m_we) check("m_MemRData", bus.MemRData, e_rdata);
            end
        end
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.IfReq = 1'b0; bus.IfAddr = '0;
        bus.MemReq = 1'b0; bus.MemWe = 1'b0; bus.MemAddr = '0; bus.MemWData = '0; bus.MemWMask = '0;
        bus.BusReady = 1'b0; bus.BusRespValid = 1'b0; bus.BusRData = '0; bus.BusRespErr = 1'b0;
    endtask

    task automatic reset_checks(input string tag);
        check({tag, "_BusValid"}, 64'(bus.BusValid), 64'd0);
        check({tag, "_BusAddr"}, bus.BusAddr, 64'd0);
        check({tag, "_BusWe"}, 64'(bus.BusWe), 64'd0);
        check({tag, "_BusWData"}, bus.BusWData, 64'd0);
        check({tag, "_BusWMask"}, 64'(bus.BusWMask), 64'd0);
        check({tag, "_IfDone"}, 64'(bus.IfDone), 64'd0);
        check({tag, "_MemDone"}, 64'(bus.MemDone), 64'd0);
        check({tag, "_IfErr"}, 64'(bus.IfErr), 64'd0);
        check({tag, "_MemErr"}, 64'(bus.MemErr), 64'd0);
        check({tag, "_IfRData"}, bus.IfRData, 64'd0);
        check({tag, "_MemRData"}, bus.MemRData, 64'd0);
    endtask

    // who: 0 = fetch completed, 1 = LSU completed, -1 = nothing within budget.
    task automatic wait_done(input int budget, output int who);
        who = -1;
        for (int i = 0; i < budget && who < 0; i++) begin
            tick();
            if (bus.IfDone) who = 0;
            else if (bus.MemDone) who = 1;
        end
    endtask

    initial begin
        int who;
        int n;
        int rdy_pct;
        int rsp_pct;

        clear_inputs();
        tick();
        tick();
        reset_checks("por");
        Rst = 1'b0;

        // Tie after reset: Mem first, then strict alternation.
        bus.IfReq = 1'b1;  bus.IfAddr = 64'h1000;
        bus.MemReq = 1'b1; bus.MemAddr = 64'h2000;
        bus.BusReady = 1'b1; bus.BusRespValid = 1'b1; bus.BusRData = 64'h55;
        for (int k = 0; k < 4; k++) begin
            wait_done(20, who);
            check("tie_order", 64'(who), (k % 2 == 0) ? 64'd1 : 64'd0);
        end
        clear_inputs();
        tick();
        tick();

        // Single fetch.
        bus.IfReq = 1'b1; bus.IfAddr = 64'h8000_0000;
        tick();
        check("fetch_BusValid", 64'(bus.BusValid), 64'd1);
        check("fetch_BusAddr", bus.BusAddr, 64'h8000_0000);
        check("fetch_BusWe", 64'(bus.BusWe), 64'd0);
        bus.BusReady = 1'b1;
        tick();
        bus.BusReady = 1'b0;
        check("fetch_valid_drop", 64'(bus.BusValid), 64'd0);
        bus.BusRespValid = 1'b1; bus.BusRData = 64'h13;
        tick();
        bus.BusRespValid = 1'b0;
        check("fetch_IfDone", 64'(bus.IfDone), 64'd1);
        check("fetch_IfRData", bus.IfRData, 64'h13);
        check("fetch_IfErr", 64'(bus.IfErr), 64'd0);
        check("fetch_MemDone", 64'(bus.MemDone), 64'd0);
        bus.IfReq = 1'b0;
        tick();
        check("fetch_pulse_end", 64'(bus.IfDone), 64'd0);

        // Store.
        bus.MemReq = 1'b1; bus.MemWe = 1'b1; bus.MemAddr = 64'h8000_1000;
        bus.MemWData = 64'hDEAD_BEEF; bus.MemWMask = 8'h0F;
        tick();
        check("store_BusAddr", bus.BusAddr, 64'h8000_1000);
        check("store_BusWe", 64'(bus.BusWe), 64'd1);
        check("store_BusWData", bus.BusWData, 64'hDEAD_BEEF);
        check("store_BusWMask", 64'(bus.BusWMask), 64'h0F);
        bus.BusReady = 1'b1;
        tick();
        bus.BusReady = 1'b0; bus.BusRespValid = 1'b1; bus.BusRespErr = 1'b0;
        tick();
        bus.BusRespValid = 1'b0;
        check("store_MemDone", 64'(bus.MemDone), 64'd1);
        check("store_MemErr", 64'(bus.MemErr), 64'd0);
        bus.MemReq = 1'b0; bus.MemWe = 1'b0;
        tick();

        // Backpressure: ten cycles without BusReady.
        bus.IfReq = 1'b1; bus.IfAddr = 64'h8000_0040;
        tick();
        for (int i = 0; i < 10; i++) begin
            check("bp_BusValid", 64'(bus.BusValid), 64'd1);
            check("bp_BusAddr", bus.BusAddr, 64'h8000_0040);
            check("bp_no_done", 64'(bus.IfDone | bus.MemDone), 64'd0);
            tick();
        end
        bus.BusReady = 1'b1;
        tick();
        bus.BusReady = 1'b0; bus.BusRespValid = 1'b1; bus.BusRData = 64'hABCD;
        tick();
        bus.BusRespValid = 1'b0;
        check("bp_IfDone", 64'(bus.IfDone), 64'd1);
        check("bp_IfRData", bus.IfRData, 64'hABCD);
        bus.IfReq = 1'b0;
        tick();

        // Timeout: no response after the handshake.
        bus.IfReq = 1'b1; bus.IfAddr = 64'h8000_0080;
        tick();
        bus.BusReady = 1'b1;
        tick();
        bus.BusReady = 1'b0;
        n = 0;
        while (n < 20 && !bus.IfDone) begin
            tick();
            n++;
        end
        check("to_latency", 64'(n), 64'(TIMEOUT));
        check("to_IfErr", 64'(bus.IfErr), 64'd1);
        check("to_IfRData", bus.IfRData, 64'd0);
        bus.IfReq = 1'b0; bus.BusRespValid = 1'b1; bus.BusRData = 64'h77;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("to_late_ignored", 64'(bus.IfDone | bus.MemDone | bus.BusValid), 64'd0);
        end
        bus.BusRespValid = 1'b0; bus.IfReq = 1'b1; bus.IfAddr = 64'h8000_00C0;
        tick();
        check("to_back_idle", 64'(bus.BusValid), 64'd1);
        bus.BusReady = 1'b1;
        tick();
        bus.BusReady = 1'b0; bus.BusRespValid = 1'b1; bus.BusRData = 64'h1;
        tick();
        bus.BusRespValid = 1'b0;
        check("to_next_done", 64'(bus.IfDone), 64'd1);
        bus.IfReq = 1'b0;
        tick();

        // Reset in the middle of an LSU WAIT, then a tie must still go to Mem.
        bus.MemReq = 1'b1; bus.MemWe = 1'b0; bus.MemAddr = 64'h3000;
        tick();
        bus.BusReady = 1'b1;
        tick();
        bus.BusReady = 1'b0;
        tick();
        tick();
        Rst = 1'b1; bus.IfReq = 1'b1; bus.IfAddr = 64'h4000;
        tick();
        reset_checks("rst");
        Rst = 1'b0;
        tick();
        check("rst_tie_valid", 64'(bus.BusValid), 64'd1);
        check("rst_tie_addr", bus.BusAddr, 64'h3000);
        bus.BusReady = 1'b1;
        tick();
        bus.BusReady = 1'b0; bus.BusRespValid = 1'b1; bus.BusRData = 64'h99;
        tick();
        bus.BusRespValid = 1'b0;
        check("rst_MemDone", 64'(bus.MemDone), 64'd1);
        check("rst_MemRData", bus.MemRData, 64'h99);
        bus.MemReq = 1'b0;
        bus.BusReady = 1'b1; bus.BusRespValid = 1'b1;
        wait_done(20, who);
        check("rst_then_if", 64'(who), 64'd0);
        clear_inputs();
        tick();
        tick();

        // Randomized traffic; the model checks every cycle.
        for (int c = 0; c < 4000; c++) begin
            tick();
            rdy_pct = (c < 2000) ? 60 : 75;
            rsp_pct = (c < 2000) ? 35 : 3;
            if (Rst) Rst = 1'b0;
            else if ($urandom_range(0, 599) == 0) Rst = 1'b1;
            if (!bus.IfReq || bus.IfDone) begin
                bus.IfReq  = ($urandom_range(0, 2) == 0);
                bus.IfAddr = {$urandom(), $urandom()};
            end
            if (!bus.MemReq || bus.MemDone) begin
                bus.MemReq   = ($urandom_range(0, 2) == 0);
                bus.MemWe    = ($urandom_range(0, 1) == 1);
                bus.MemAddr  = {$urandom(), $urandom()};
                bus.MemWData = {$urandom(), $urandom()};
                bus.MemWMask = 8'($urandom_range(0, 255));
            end
            bus.BusReady     = ($urandom_range(0, 99) < rdy_pct);
            bus.BusRespValid = ($urandom_range(0, 99) < rsp_pct);
            bus.BusRData     = {$urandom(), $urandom()};
            bus.BusRespErr   = ($urandom_range(0, 7) == 0);
        end
        Rst = 1'b0;
        clear_inputs();
        for (int i = 0; i < 20; i++) tick();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
